regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_REGS_LOG, 3, register address width.
- DATA_WIDTH, 64, register data width.
- READ_LAT, 2, clock edges from rf_ra*_o update to valid rf_rd*_i.
- WR_GAP, 2, cycles a written address stays read-blocked.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle if cmd_valid_i also high.
- cmd_we_i  in  1  1 = write, 0 = dual read.
- cmd_ra0_i, cmd_ra1_i  in  NUM_REGS_LOG  read addresses.
- cmd_wa_i  in  NUM_REGS_LOG  write address.
- cmd_wd_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  read response present.
- rsp_ready_i  in  1  response consumed.
- rsp_rd0_o, rsp_rd1_o  out  DATA_WIDTH  read data for ra0 and ra1.
- rf_wen_o  out  1  write enable to the register file wrapper.
- rf_ra0_o, rf_ra1_o, rf_wa_o  out  NUM_REGS_LOG  register file addresses.
- rf_wd_o  out  DATA_WIDTH  register file write data.
- rf_rd0_i, rf_rd1_i  in  DATA_WIDTH  register file read data.
REQ-003 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-004 All outputs except cmd_ready_o SHALL be driven directly from flops.

Function
REQ-005 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-006 Accept SHALL occur when cmd_valid_i && cmd_ready_o is sampled on an edge E.
REQ-007 cmd_ready_o SHALL be 0 in WAIT and RESP.
REQ-008 In IDLE, cmd_ready_o SHALL be 1 except during a read hazard (REQ-013).
REQ-009 Write accept at E:
- rf_wen_o=1, rf_wa_o=cmd_wa_i and rf_wd_o=cmd_wd_i from E.
- rf_wen_o SHALL return to 0 at E+1 unless another write is accepted at E+1.
- State SHALL remain IDLE, so back-to-back writes sustain one per cycle.
REQ-010 Read accept at E:
- rf_ra0_o/rf_ra1_o SHALL load at E.
- State SHALL go to WAIT with a latency counter loaded to READ_LAT.
- rf_wen_o=0 from E.
REQ-011 In WAIT, the counter SHALL decrement every edge. On the edge where it is 0 (E+READ_LAT+1), the block SHALL:
- capture rf_rd0_i/rf_rd1_i into rsp_rd0_o/rsp_rd1_o;
- set rsp_valid_o=1;
- move to RESP.
REQ-012 In RESP, rsp_valid_o and the data SHALL hold stable until an edge samples rsp_ready_i=1. That edge SHALL clear rsp_valid_o and move to IDLE; no command is accepted on that edge.
REQ-013 Hazard tracking:
- Each write accept SHALL record rf_wa_o and load a gap counter to WR_GAP.
- The gap counter SHALL decrement to 0 and saturate there.
- In IDLE, a read with cmd_ra0_i or cmd_ra1_i equal to the recorded address while gap counter != 0 SHALL see cmd_ready_o=0.
- Non-matching reads and all writes SHALL NOT be blocked.
REQ-014 A write accepted at E followed by a matching read held valid SHALL be accepted no earlier than E+WR_GAP+1.
REQ-015 rf_ra*_o SHALL hold their last value outside read accepts. rf_wa_o/rf_wd_o SHALL hold their last value outside write accepts.
REQ-016 Register 0 SHALL NOT be special; every address is readable and writable.
REQ-017 Command fields SHALL be ignored when cmd_valid_i=0 or cmd_ready_o=0.

Reset
REQ-018 With reset high on an edge, the block SHALL force:
- state=IDLE;
- rsp_valid_o=0 and rf_wen_o=0;
- rf_ra0_o, rf_ra1_o, rf_wa_o, rf_wd_o, rsp_rd0_o, rsp_rd1_o all 0;
- latency counter=0 and gap counter=0.
REQ-019 Reset SHALL override any accept on the same edge.
REQ-020 Reset in WAIT or RESP SHALL discard the in-flight read, with no response ever produced for it.
REQ-021 cmd_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write r5=0xDEAD_BEEF at E: rf_wen_o=1 for exactly one cycle, rf_wa_o=5, rf_wd_o=0xDEADBEEF.
- After a settled write of r5, read ra0=5, ra1=2 accepted at E: rsp_valid_o rises at E+3 with rsp_rd0_o=0xDEADBEEF; cmd_ready_o=0 through RESP.
- rsp_ready_i held 0 for 4 cycles: rsp data stable and rsp_valid_o=1 throughout; the edge with rsp_ready_i=1 returns the FSM to IDLE with cmd_ready_o=1 next cycle.
- Write r3 at E, then read ra1=3 presented at E+1: cmd_ready_o=0 at E+1 and E+2, accept at E+3, read returns the new r3 value. A read of r4 at E+1 is accepted immediately.
- Four back-to-back writes r0..r3: four consecutive rf_wen_o=1 cycles with matching rf_wa_o/rf_wd_o.
- Reset asserted the cycle after a read accept: no rsp_valid_o ever, all outputs 0, cmd_ready_o=1 after reset release.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences writes and fixed-latency dual reads to a register file, blocking reads of just-written addresses.
module regfile_access_ctrl #(
    parameter int NUM_REGS_LOG = 3,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LAT     = 2,
    parameter int WR_GAP       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [NUM_REGS_LOG-1:0] cmd_ra0_i,
    input  logic [NUM_REGS_LOG-1:0] cmd_ra1_i,
    input  logic [NUM_REGS_LOG-1:0] cmd_wa_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wd_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rd0_o,
    output logic [DATA_WIDTH-1:0]   rsp_rd1_o,
    output logic                    rf_wen_o,
    output logic [NUM_REGS_LOG-1:0] rf_ra0_o,
    output logic [NUM_REGS_LOG-1:0] rf_ra1_o,
    output logic [NUM_REGS_LOG-1:0] rf_wa_o,
    output logic [DATA_WIDTH-1:0]   rf_wd_o,
    input  logic [DATA_WIDTH-1:0]   rf_rd0_i,
    input  logic [DATA_WIDTH-1:0]   rf_rd1_i
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int LW = $clog2(READ_LAT + 2);
    localparam int GW = $clog2(WR_GAP + 2);
    state_e                  state_q;
    logic [LW-1:0]           lat_q;
    logic [GW-1:0]           gap_q;
    logic                    rsp_valid_q, wen_q;
    logic [DATA_WIDTH-1:0]   rd0_q, rd1_q, wd_q;
    logic [NUM_REGS_LOG-1:0] ra0_q, ra1_q, wa_q;
    logic                    hazard, accept, wr_acc, rd_acc;
    // rf_wa_o doubles as the recorded hazard address
    assign hazard      = !cmd_we_i && gap_q != '0 && (cmd_ra0_i == wa_q || cmd_ra1_i == wa_q);
    assign cmd_ready_o = state_q == IDLE && !hazard;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign wr_acc      = accept && cmd_we_i;
    assign rd_acc      = accept && !cmd_we_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rd0_o   = rd0_q;
    assign rsp_rd1_o   = rd1_q;
    assign rf_wen_o    = wen_q;
    assign rf_ra0_o    = ra0_q;
    assign rf_ra1_o    = ra1_q;
    assign rf_wa_o     = wa_q;
    assign rf_wd_o     = wd_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            rd0_q       <= '0;
            rd1_q       <= '0;
            wd_q        <= '0;
            ra0_q       <= '0;
            ra1_q       <= '0;
            wa_q        <= '0;
        end else begin
            wen_q <= wr_acc;
            gap_q <= wr_acc ? GW'(WR_GAP) : (gap_q != '0 ? gap_q - GW'(1) : gap_q);
            if (wr_acc) begin
                wa_q <= cmd_wa_i;
                wd_q <= cmd_wd_i;
            end
            if (rd_acc) begin
                ra0_q <= cmd_ra0_i;
                ra1_q <= cmd_ra1_i;
            end
            case (state_q)
                IDLE: if (rd_acc) begin
                    lat_q   <= LW'(READ_LAT);
                    state_q <= WAIT;
                end
                WAIT: if (lat_q == '0) begin
                    rd0_q       <= rf_rd0_i;
                    rd1_q       <= rf_rd1_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end else begin
                    lat_q <= lat_q - LW'(1);
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed checks of regfile_access_ctrl against a 2-edge-latency register file model.
module tb_regfile_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [2:0]  cmd_ra0_i, cmd_ra1_i, cmd_wa_i;
    logic [63:0] cmd_wd_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [63:0] rsp_rd0_o, rsp_rd1_o;
    logic        rf_wen_o;
    logic [2:0]  rf_ra0_o, rf_ra1_o, rf_wa_o;
    logic [63:0] rf_wd_o, rf_rd0_i, rf_rd1_i;
    logic [63:0] mem [8];
    logic [63:0] s0, s1;
    int          errors = 0;
    int          checks = 0;

    regfile_access_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_ra0_i(cmd_ra0_i), .cmd_ra1_i(cmd_ra1_i), .cmd_wa_i(cmd_wa_i), .cmd_wd_i(cmd_wd_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rd0_o(rsp_rd0_o), .rsp_rd1_o(rsp_rd1_o),
        .rf_wen_o(rf_wen_o), .rf_ra0_o(rf_ra0_o), .rf_ra1_o(rf_ra1_o),
        .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o), .rf_rd0_i(rf_rd0_i), .rf_rd1_i(rf_rd1_i)
    );

    always #5 clk = ~clk;

    // register file wrapper: data for a new address appears two edges later
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (rf_wen_o) begin
            mem[rf_wa_o] <= rf_wd_o;
        end
        s0       <= mem[rf_ra0_o];
        s1       <= mem[rf_ra1_o];
        rf_rd0_i <= s0;
        rf_rd1_i <= s1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cmd_valid_i = 0; cmd_we_i = 0; cmd_ra0_i = 0; cmd_ra1_i = 0;
        cmd_wa_i = 0; cmd_wd_i = 0; rsp_ready_i = 0;
        step(); step();
        chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("rst_wen", 64'(rf_wen_o), 0);
        chk("rst_ra0", 64'(rf_ra0_o), 0);
        chk("rst_wd", rf_wd_o, 0);
        chk("rst_rd0", rsp_rd0_o, 0);
        reset = 1'b0;
        #1 chk("rst_ready_after", 64'(cmd_ready_o), 1);

        // single write r5
        cmd_valid_i = 1; cmd_we_i = 1; cmd_wa_i = 5; cmd_wd_i = 64'hDEAD_BEEF;
        step();
        chk("wr5_wen", 64'(rf_wen_o), 1);
        chk("wr5_wa", 64'(rf_wa_o), 5);
        chk("wr5_wd", rf_wd_o, 64'hDEAD_BEEF);
        cmd_valid_i = 0; cmd_wd_i = 0; cmd_wa_i = 0;
        step();
        chk("wr5_wen_drop", 64'(rf_wen_o), 0);
        chk("wr5_wd_hold", rf_wd_o, 64'hDEAD_BEEF);
        step();

        // read ra0=5 ra1=2
        cmd_valid_i = 1; cmd_we_i = 0; cmd_ra0_i = 5; cmd_ra1_i = 2;
        #1 chk("rd_ready", 64'(cmd_ready_o), 1);
        step();
        cmd_valid_i = 0;
        chk("rd_ra0", 64'(rf_ra0_o), 5);
        chk("rd_ra1", 64'(rf_ra1_o), 2);
        chk("rd_wait_ready", 64'(cmd_ready_o), 0);
        chk("rd_wen", 64'(rf_wen_o), 0);
        step(); chk("rd_valid_e1", 64'(rsp_valid_o), 0);
        step(); chk("rd_valid_e2", 64'(rsp_valid_o), 0);
        step();
        chk("rd_valid_e3", 64'(rsp_valid_o), 1);
        chk("rd_rd0", rsp_rd0_o, 64'hDEAD_BEEF);
        chk("rd_rd1", rsp_rd1_o, 0);

        // backpressure then release; a write offered on the release edge is ignored
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", 64'(rsp_valid_o), 1);
            chk("bp_rd0", rsp_rd0_o, 64'hDEAD_BEEF);
            chk("bp_ready", 64'(cmd_ready_o), 0);
        end
        rsp_ready_i = 1; cmd_valid_i = 1; cmd_we_i = 1; cmd_wa_i = 7; cmd_wd_i = 64'h77;
        step();
        rsp_ready_i = 0; cmd_valid_i = 0; cmd_we_i = 0;
        chk("rel_valid", 64'(rsp_valid_o), 0);
        chk("rel_no_accept", 64'(rf_wen_o), 0);
        chk("rel_wa_hold", 64'(rf_wa_o), 5);
        #1 chk("rel_ready", 64'(cmd_ready_o), 1);

        // back-to-back writes r0..r3
        for (int i = 0; i < 4; i++) begin
            cmd_valid_i = 1; cmd_we_i = 1; cmd_wa_i = 3'(i); cmd_wd_i = 64'h1000 + 64'(i);
            step();
            chk("b2b_wen", 64'(rf_wen_o), 1);
            chk("b2b_wa", 64'(rf_wa_o), 64'(i));
            chk("b2b_wd", rf_wd_o, 64'h1000 + 64'(i));
        end
        cmd_valid_i = 0;
        step();
        chk("b2b_wen_drop", 64'(rf_wen_o), 0);
        step();

        // write r3 then matching read held valid
        cmd_valid_i = 1; cmd_we_i = 1; cmd_wa_i = 3; cmd_wd_i = 64'h3333_CAFE;
        step();
        chk("haz_wen", 64'(rf_wen_o), 1);
        cmd_we_i = 0; cmd_ra0_i = 1; cmd_ra1_i = 3;
        #1 chk("haz_block_e1", 64'(cmd_ready_o), 0);
        step();
        chk("haz_block_e2", 64'(cmd_ready_o), 0);
        step();
        chk("haz_open_e3", 64'(cmd_ready_o), 1);
        step();
        cmd_valid_i = 0;
        chk("haz_accepted", 64'(cmd_ready_o), 0);
        chk("haz_ra1", 64'(rf_ra1_o), 3);
        step(); step(); step();
        chk("haz_valid", 64'(rsp_valid_o), 1);
        chk("haz_rd0", rsp_rd0_o, 64'h1001);
        chk("haz_rd1", rsp_rd1_o, 64'h3333_CAFE);
        rsp_ready_i = 1;
        step();
        rsp_ready_i = 0;

        // write r6 then non-matching read of r4/r0 goes straight in
        cmd_valid_i = 1; cmd_we_i = 1; cmd_wa_i = 6; cmd_wd_i = 64'h6;
        step();
        cmd_we_i = 0; cmd_ra0_i = 4; cmd_ra1_i = 0;
        #1 chk("nohaz_ready", 64'(cmd_ready_o), 1);
        step();
        cmd_valid_i = 0;
        chk("nohaz_ra0", 64'(rf_ra0_o), 4);
        chk("nohaz_wait", 64'(cmd_ready_o), 0);
        step(); step(); step();
        chk("nohaz_valid", 64'(rsp_valid_o), 1);
        chk("nohaz_rd1", rsp_rd1_o, 64'h1000);
        rsp_ready_i = 1;
        step();
        rsp_ready_i = 0;

        // reset the cycle after a read accept, with a write offered on the reset edge
        cmd_valid_i = 1; cmd_we_i = 0; cmd_ra0_i = 5; cmd_ra1_i = 5;
        step();
        chk("rr_accept", 64'(rf_ra0_o), 5);
        reset = 1; cmd_we_i = 1; cmd_wa_i = 7; cmd_wd_i = 64'h99;
        step();
        chk("rr_valid", 64'(rsp_valid_o), 0);
        chk("rr_wen", 64'(rf_wen_o), 0);
        chk("rr_ra0", 64'(rf_ra0_o), 0);
        chk("rr_ra1", 64'(rf_ra1_o), 0);
        chk("rr_wa", 64'(rf_wa_o), 0);
        chk("rr_wd", rf_wd_o, 0);
        chk("rr_rd0", rsp_rd0_o, 0);
        chk("rr_rd1", rsp_rd1_o, 0);
        reset = 0; cmd_valid_i = 0; cmd_we_i = 0;
        #1 chk("rr_ready", 64'(cmd_ready_o), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_no_rsp", 64'(rsp_valid_o), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
